// File: rtl/mab_pkg.sv
// Shared types and constants for the camera-to-SRAM write bridge.
// Holds the byte-phase encoding, the address width default and reset levels of the strobes.
package mab_pkg;

  localparam int unsigned ADDR_W_DEF = 16;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } byte_phase_e;

  localparam logic WEB_RST  = 1'b1;
  localparam logic BLEB_RST = 1'b1;
  localparam logic BHEB_RST = 1'b1;

  // Active-low lane enables {BHEb, BLEb} for a write in the given byte phase.
  function automatic logic [1:0] lane_enables(input byte_phase_e ph);
    logic [1:0] en;
    case (ph)
      PH_LO:   en = 2'b10;
      PH_HI:   en = 2'b01;
      default: en = 2'b11;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/mem_addr_bridge_if.sv
// Camera-port and SRAM-pin bundle of the write bridge.
// The master modport is the bridge side; the slave modport is the camera/SRAM side.
interface mem_addr_bridge_if
  import mab_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              pclk;
  logic              HREF;
  logic              VSYNC;
  logic              xclk;
  logic              WEb;
  logic              BLEb;
  logic              BHEb;
  logic [ADDR_W-1:0] SRAM_address;

  modport master (
    input  pclk,
    input  HREF,
    input  VSYNC,
    output xclk,
    output WEb,
    output BLEb,
    output BHEb,
    output SRAM_address
  );

  modport slave (
    output pclk,
    output HREF,
    output VSYNC,
    input  xclk,
    input  WEb,
    input  BLEb,
    input  BHEb,
    input  SRAM_address
  );

endinterface

// File: rtl/mem_addr_bridge_edge_det.sv
// Samples pclk/HREF/VSYNC in the system clock and flags each qualified pclk rising edge.
// pclk is treated purely as data; the event is derived from the current and previous samples.
module pclk_edge_det
  import mab_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pclk_i,
  input  logic href_i,
  input  logic vsync_i,
  output logic byte_evt_o,
  output logic href_o,
  output logic vsync_o
);

  logic pclk_q;
  logic pclk_prev_q;
  logic href_q;
  logic vsync_q;

  // Input sampling; VSYNC resets high so nothing is written until the first frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q      <= 1'b0;
      pclk_prev_q <= 1'b0;
      href_q      <= 1'b0;
      vsync_q     <= 1'b1;
    end else begin
      pclk_q      <= pclk_i;
      pclk_prev_q <= pclk_q;
      href_q      <= href_i;
      vsync_q     <= vsync_i;
    end
  end

  assign byte_evt_o = pclk_q & ~pclk_prev_q & href_q & ~vsync_q;
  assign href_o     = href_q;
  assign vsync_o    = vsync_q;

endmodule

// File: rtl/mem_addr_bridge.sv
// Camera-to-SRAM write bridge: xclk divider, byte-phase tracking, write strobes and word address.
// Define MAB_SATURATE_EN to make the address stop at its maximum instead of wrapping.
module mem_addr_bridge
  import mab_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_addr_bridge_if.master bus
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic byte_evt_s;
  logic href_s;
  logic vsync_s;
  logic write_ok_s;

  logic              xclk_q;
  byte_phase_e       phase_q, phase_d;
  logic              web_q, web_d;
  logic              bleb_q, bleb_d;
  logic              bheb_q, bheb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  pclk_edge_det u_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .pclk_i     (bus.pclk),
    .href_i     (bus.HREF),
    .vsync_i    (bus.VSYNC),
    .byte_evt_o (byte_evt_s),
    .href_o     (href_s),
    .vsync_o    (vsync_s)
  );

`ifdef MAB_SATURATE_EN
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  logic sat_q, sat_d;

  assign write_ok_s = ~sat_q;

  // Saturation flag: set once the top word has been written, cleared by frame blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`else
  assign write_ok_s = 1'b1;
`endif

  // Camera master clock at half the system clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xclk_q <= 1'b0;
    end else begin
      xclk_q <= ~xclk_q;
    end
  end

  // Strobe, phase and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_LO;
      web_q   <= WEB_RST;
      bleb_q  <= BLEB_RST;
      bheb_q  <= BHEB_RST;
      addr_q  <= ADDR_ZERO;
    end else begin
      phase_q <= phase_d;
      web_q   <= web_d;
      bleb_q  <= bleb_d;
      bheb_q  <= bheb_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: the address advances as a high-lane pulse ends; VSYNC overrides everything.
  always_comb begin
    web_d   = WEB_RST;
    bleb_d  = BLEB_RST;
    bheb_d  = BHEB_RST;
    phase_d = phase_q;
    addr_d  = addr_q;
`ifdef MAB_SATURATE_EN
    sat_d   = sat_q;
`endif

    if (!web_q && !bheb_q) begin
`ifdef MAB_SATURATE_EN
      if (addr_q == ADDR_MAX) begin
        sat_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_ONE;
      end
`else
      addr_d = addr_q + ADDR_ONE;
`endif
    end else begin
      addr_d = addr_q;
    end

    if (vsync_s) begin
      addr_d  = ADDR_ZERO;
      phase_d = PH_LO;
`ifdef MAB_SATURATE_EN
      sat_d   = 1'b0;
`endif
    end else if (!href_s) begin
      phase_d = PH_LO;
    end else if (byte_evt_s && write_ok_s) begin
      web_d            = 1'b0;
      {bheb_d, bleb_d} = lane_enables(phase_q);
      case (phase_q)
        PH_LO:   phase_d = PH_HI;
        PH_HI:   phase_d = PH_LO;
        default: phase_d = PH_LO;
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  assign bus.xclk         = xclk_q;
  assign bus.WEb          = web_q;
  assign bus.BLEb         = bleb_q;
  assign bus.BHEb         = bheb_q;
  assign bus.SRAM_address = addr_q;

endmodule

// File: tb/tb_mem_addr_bridge.sv
// Scoreboard bench for mem_addr_bridge: a byte-level reference model queues expected writes,
// and a monitor pops and compares them whenever WEb is low.
module tb_mem_addr_bridge;

  localparam int AW     = 10;
  localparam int AWORDS = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_addr_bridge_if #(.ADDR_W(AW)) bus ();

  mem_addr_bridge #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [AW:0] exp_q[$];
  int m_addr  = 0;
  bit m_phase = 1'b0;
  bit m_sat   = 1'b0;
  logic xclk_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One pclk period: pclk low with new HREF/VSYNC, then pclk high. Model updated per byte.
  task automatic pix(input bit h, input bit v);
    @(negedge clk);
    bus.pclk  = 1'b0;
    bus.HREF  = h;
    bus.VSYNC = v;
    if (v) begin
      m_addr = 0; m_phase = 1'b0; m_sat = 1'b0;
    end else if (!h) begin
      m_phase = 1'b0;
    end else if (!m_sat) begin
      exp_q.push_back({m_phase, AW'(m_addr)});
      if (m_phase) begin
`ifdef MAB_SATURATE_EN
        if (m_addr == AWORDS - 1) m_sat = 1'b1;
        else m_addr = m_addr + 1;
`else
        m_addr = (m_addr + 1) % AWORDS;
`endif
      end
      m_phase = ~m_phase;
    end
    @(negedge clk);
    bus.pclk = 1'b1;
  endtask

  task automatic line(input int bytes, input int gap);
    repeat (bytes) pix(1'b1, 1'b0);
    repeat (gap) pix(1'b0, 1'b0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) xclk_exp <= 1'b0;
    else        xclk_exp <= ~xclk_exp;
  end

  // Monitor: every cycle checks xclk and idle lanes, and pops one expectation per write pulse.
  always @(negedge clk) begin
    logic [AW:0] e;
    if (rst_n) begin
      chk("xclk", {31'd0, bus.xclk}, {31'd0, xclk_exp});
      if (bus.WEb) begin
        chk("idle_lanes", {30'd0, bus.BLEb, bus.BHEb}, 32'd3);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h lanes %b%b with empty queue",
                 bus.SRAM_address, bus.BLEb, bus.BHEb);
      end else begin
        e = exp_q.pop_front();
        chk("write_lanes", {30'd0, bus.BLEb, bus.BHEb}, e[AW] ? 32'd2 : 32'd1);
        chk("write_addr", 32'(bus.SRAM_address), 32'(e[AW-1:0]));
      end
    end
  end

  initial begin
    int len;
    bus.pclk  = 1'b0;
    bus.HREF  = 1'b0;
    bus.VSYNC = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_web",  {31'd0, bus.WEb},  32'd1);
    chk("rst_bleb", {31'd0, bus.BLEb}, 32'd1);
    chk("rst_bheb", {31'd0, bus.BHEb}, 32'd1);
    chk("rst_addr", 32'(bus.SRAM_address), 32'd0);
    chk("rst_xclk", {31'd0, bus.xclk}, 32'd0);
    rst_n = 1'b1;

    // Idle in vertical blanking.
    repeat (10) pix(1'b0, 1'b1);
    chk("idle_addr", 32'(bus.SRAM_address), 32'd0);

    // One full line: 640 bytes, 320 words.
    line(640, 4);
    chk("line1_addr", 32'(bus.SRAM_address), 32'h140);

    // Three lines with blanking gaps.
    repeat (2) pix(1'b0, 1'b1);
    repeat (3) line(640, 288);
    chk("line3_addr", 32'(bus.SRAM_address), 32'h3C0);

    // Odd byte count: dangling low byte does not advance.
    repeat (2) pix(1'b0, 1'b1);
    line(3, 4);
    chk("odd_addr", 32'(bus.SRAM_address), 32'd1);
    line(4, 4);
    chk("odd_next_addr", 32'(bus.SRAM_address), 32'd3);

    // VSYNC raised mid-line.
    repeat (2) pix(1'b0, 1'b1);
    repeat (10) pix(1'b1, 1'b0);
    repeat (5) pix(1'b1, 1'b1);
    chk("vsync_addr", 32'(bus.SRAM_address), 32'd0);
    chk("vsync_web", {31'd0, bus.WEb}, 32'd1);
    line(4, 3);
    chk("post_vsync_addr", 32'(bus.SRAM_address), 32'd2);

    // Frame longer than the address space.
    repeat (2) pix(1'b0, 1'b1);
    repeat (4) line(640, 20);
`ifdef MAB_SATURATE_EN
    chk("frame_addr", 32'(bus.SRAM_address), 32'(AWORDS - 1));
`else
    chk("frame_addr", 32'(bus.SRAM_address), 32'((4 * 320) % AWORDS));
`endif

    // Randomized lines, gaps and mid-line VSYNC.
    for (int i = 0; i < 15; i++) begin
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) pix(1'b0, 1'b1);
      len = $urandom_range(700, 1);
      if ($urandom_range(7, 0) == 0) begin
        repeat (len / 2) pix(1'b1, 1'b0);
        repeat ($urandom_range(3, 1)) pix(1'b1, 1'b1);
        repeat (len - len / 2) pix(1'b1, 1'b0);
      end else begin
        repeat (len) pix(1'b1, 1'b0);
      end
      repeat ($urandom_range(40, 2)) pix(1'b0, 1'b0);
      chk("rand_addr", 32'(bus.SRAM_address), 32'(m_addr));
    end

    // Reset asserted while a write pulse is low.
    repeat (2) pix(1'b0, 1'b1);
    repeat (5) pix(1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_web", {31'd0, bus.WEb}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_web",  {31'd0, bus.WEb},  32'd1);
    chk("midrst_bleb", {31'd0, bus.BLEb}, 32'd1);
    chk("midrst_bheb", {31'd0, bus.BHEb}, 32'd1);
    chk("midrst_addr", 32'(bus.SRAM_address), 32'd0);
    chk("midrst_xclk", {31'd0, bus.xclk}, 32'd0);
    exp_q.delete();
    m_addr = 0; m_phase = 1'b0; m_sat = 1'b0;
    @(negedge clk);
    bus.pclk  = 1'b0;
    bus.HREF  = 1'b0;
    bus.VSYNC = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) pix(1'b0, 1'b1);
    line(6, 4);
    chk("post_rst_addr", 32'(bus.SRAM_address), 32'd3);

    repeat (4) pix(1'b0, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
